// File: rtl/async_fifo_pkg.sv
// Shared async FIFO helpers: Gray/binary conversion and default pointer sizes.
// The conversion functions work on a wide vector; callers zero-extend their
// WIDTH-bit pointer into ptr_vec_t and cast the result back to WIDTH bits.
package async_fifo_pkg;

    localparam int ADDBITS_DEF = 2;
    localparam int WIDTH_DEF   = ADDBITS_DEF + 1;
    localparam int PTR_MAX_W   = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_vec_t;

    function automatic ptr_vec_t bin2gray(input ptr_vec_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_vec_t gray2bin(input ptr_vec_t g);
        ptr_vec_t b;
        b = g;
        for (int i = 1; i < PTR_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter.sv
// Binary/Gray pointer counter shared by both FIFO sides. Holds the binary and
// Gray pointer registers and exposes the Gray value it is about to load.
module gray_counter
    import async_fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] gray_next
);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;

    // Advance the binary pointer on enable (wraps modulo 2^WIDTH) and derive its Gray code.
    always_comb begin
        bin_d = bin_q;
        if (enable) begin
            bin_d = bin_q + WIDTH'(1);
        end
        gray_d    = WIDTH'(bin2gray(ptr_vec_t'(bin_d)));
        gray_next = gray_d;
    end

    // Pointer registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;

endmodule

// File: rtl/read_pointer.sv
// Read-side pointer and empty flag for the async FIFO (read clock domain).
// Optional fill level / almost-empty outputs are built when RPTR_LEVEL_EN is
// defined; without it those ports and the level logic do not exist.
module read_pointer
    import async_fifo_pkg::*;
#(
    parameter int ADDBITS = ADDBITS_DEF,
    parameter int WIDTH   = ADDBITS + 1
`ifdef RPTR_LEVEL_EN
    ,
    parameter int AE_THRESH = 1
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               count,
    input  logic [WIDTH-1:0]   wpointer,
    output logic [WIDTH-1:0]   rpointer,
    output logic [ADDBITS-1:0] raddr,
    output logic               empty
`ifdef RPTR_LEVEL_EN
    ,
    output logic [WIDTH-1:0]   rlevel,
    output logic               almost_empty
`endif
);

    logic             enable;
    logic [WIDTH-1:0] rbin;
    logic [WIDTH-1:0] gray_next;
    logic             empty_q, empty_d;

    // A read request while empty is dropped: the pointer simply does not move.
    assign enable = count & ~empty_q;

    gray_counter #(
        .WIDTH (WIDTH)
    ) u_rd_ctr (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .bin       (rbin),
        .gray      (rpointer),
        .gray_next (gray_next)
    );

    assign raddr = rbin[ADDBITS-1:0];
    assign empty = empty_q;

    // Empty when the pointer we are about to hold equals the synchronized write pointer.
    always_comb begin
        empty_d = (gray_next == wpointer);
    end

    // Empty flag register; comes out of reset empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            empty_q <= 1'b1;
        end else begin
            empty_q <= empty_d;
        end
    end

`ifdef RPTR_LEVEL_EN
    logic [WIDTH-1:0] wbin;
    logic [WIDTH-1:0] rbin_next;
    logic [WIDTH-1:0] rlevel_q, rlevel_d;
    logic             almost_empty_q, almost_empty_d;

    // Fill level against the next read pointer; modulo arithmetic absorbs the wrap bit.
    always_comb begin
        wbin           = WIDTH'(gray2bin(ptr_vec_t'(wpointer)));
        rbin_next      = rbin + WIDTH'(enable);
        rlevel_d       = wbin - rbin_next;
        almost_empty_d = (rlevel_d <= WIDTH'(AE_THRESH));
    end

    // Level and almost-empty registers; reset to an empty FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rlevel_q       <= '0;
            almost_empty_q <= 1'b1;
        end else begin
            rlevel_q       <= rlevel_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign rlevel       = rlevel_q;
    assign almost_empty = almost_empty_q;
`else
    // Without the level logic the wrap bit of the binary pointer has no reader here.
    logic rbin_wrap_unused;
    assign rbin_wrap_unused = rbin[ADDBITS];
`endif

endmodule
